// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and digit-count helpers for the serial adder
package adder_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int calc_cw(input int width, input int digit);
    return (width / digit) > 1 ? $clog2(width / digit) : 1;
  endfunction
endpackage

// File: rtl/adder_full_1bit.sv
// adder_full_1bit: single-bit full adder
module adder_full_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/adder_full_nbit.sv
// adder_full_nbit: DIGIT-bit ripple adder exposing the carry into its MSB
module adder_full_nbit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [DIGIT:0] c;
  assign c[0]  = ci;
  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    adder_full_1bit u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
endmodule

// File: rtl/adder_serial_nbit.sv
// adder_serial_nbit: multi-cycle add/subtract processing DIGIT bits per clock, LSB first
module adder_serial_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] Add,
  input  logic [WIDTH-1:0] Aug,
  input  logic             PreC,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             ProC,
  output logic             Ovf
);
  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = calc_cw(WIDTH, DIGIT);
  if (WIDTH % DIGIT != 0 || WIDTH < 2) begin : g_bad_param
    $error("adder_serial_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic c_q, c_d, sub_q, sub_d, busy_q, busy_d, done_q, done_d, proc_q, proc_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] s_dig;
  logic co, cm, accept, run, last;
  logic [WIDTH+DIGIT-1:0] cat;
  adder_full_nbit #(.DIGIT(DIGIT)) u_digit (
    .a(a_q[DIGIT-1:0]), .b(b_q[DIGIT-1:0]), .ci(c_q), .s(s_dig), .co(co), .c_msb(cm)
  );
  always_comb begin
    accept  = Start && state_q != ST_RUN;
    run     = state_q == ST_RUN;
    last    = cnt_q == CW'(N - 1);
    cat     = {s_dig, acc_q};
    state_d = accept ? ST_RUN : run ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
    a_d     = accept ? Add : run ? a_q >> DIGIT : a_q;
    b_d     = accept ? (Sub ? ~Aug : Aug) : run ? b_q >> DIGIT : b_q;
    c_d     = accept ? PreC ^ Sub : run ? co : c_q;
    sub_d   = accept ? Sub : sub_q;
    cnt_d   = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    acc_d   = accept ? '0 : run ? cat[WIDTH+DIGIT-1:DIGIT] : acc_q;
    sum_d   = run && last ? cat[WIDTH+DIGIT-1:DIGIT] : sum_q;
    proc_d  = run && last ? co ^ sub_q : proc_q;
    ovf_d   = run && last ? cm ^ co : ovf_q;
    busy_d  = state_d == ST_RUN;
    done_d  = state_d == ST_DONE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      proc_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      proc_q  <= proc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign ProC = proc_q;
  assign Ovf  = ovf_q;
endmodule
